// File: rtl/oled_frame_reader_if.sv
// ---------------------------------------------------------------------------
// oled_frame_reader_if
// Bundles the three links of the frame reader:
//   capture side : cap_frame_done (capture -> reader), cap_we_en (reader -> capture)
//   frame buffer : fb_addr (reader -> RAM), fb_pxl (RAM -> reader, 1-cycle latency)
//   OLED driver  : oled_rst, oled_color (reader -> driver),
//                  oled_next_pixel (driver -> reader)
// Modports:
//   master : the frame reader
//   slave  : the capture block / frame buffer / OLED driver collectively
// ---------------------------------------------------------------------------
interface oled_frame_reader_if #(
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 16
);
  logic                     cap_frame_done;
  logic                     cap_we_en;
  logic [c_nb_img_pxls-1:0] fb_addr;
  logic [c_nb_buf-1:0]      fb_pxl;
  logic                     oled_rst;
  logic                     oled_next_pixel;
  logic [15:0]              oled_color;

  modport master (
    input  cap_frame_done,
    output cap_we_en,
    output fb_addr,
    input  fb_pxl,
    output oled_rst,
    input  oled_next_pixel,
    output oled_color
  );

  modport slave (
    output cap_frame_done,
    input  cap_we_en,
    input  fb_addr,
    output fb_pxl,
    input  oled_rst,
    output oled_next_pixel,
    input  oled_color
  );
endinterface

// File: rtl/oled_frame_reader.sv
// ---------------------------------------------------------------------------
// oled_frame_reader
// Snapshots one 80x60 frame from the camera frame buffer and streams it to
// the OLED driver, one pixel per oled_next_pixel, converting 5/5/6 buffer
// words to RGB565. Capture writes are frozen while the frame is read out.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : one-cycle request to read one frame (ignored when busy)
//   i_continuous   : re-arm for the next frame automatically after each frame
//   bus            : capture / frame buffer / OLED link (master side)
//   o_busy         : high whenever not idle
//   o_frame_done   : one-cycle pulse after the last pixel is consumed
//   o_frame_cnt    : frames streamed, wraps
//   o_overrun      : sticky, next_pixel arrived while a fetch was pending
// ---------------------------------------------------------------------------
module oled_frame_reader #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 16,
  parameter bit c_swap_r_b    = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_continuous,
  oled_frame_reader_if.master  bus,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [7:0]           o_frame_cnt,
  output logic                 o_overrun
);

  localparam logic [c_nb_img_pxls-1:0] c_pxls_w = c_nb_img_pxls'(c_img_pxls);
  localparam logic [c_nb_img_pxls-1:0] c_one_w  = c_nb_img_pxls'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_PREFETCH   = 3'd2,
    S_STREAM     = 3'd3,
    S_DONE       = 3'd4
  } t_state;

  t_state                   r_state;
  logic                     r_cap_we_en;
  logic                     r_oled_rst;
  logic [c_nb_img_pxls-1:0] r_fb_addr;
  logic [c_nb_img_pxls-1:0] r_cnt;
  logic [15:0]              r_color;
  logic                     r_busy;
  logic                     r_frame_done;
  logic [7:0]               r_frame_cnt;
  logic                     r_overrun;
  logic                     r_pre;
  // Fetch pipeline: d1 = address just advanced, d2 = RAM data valid next edge.
  logic                     r_np_d1;
  logic                     r_np_d2;
  logic [c_nb_img_pxls-1:0] w_cnt_nxt;

  // 5/5/6 buffer word to RGB565: green MSB replicated, blue LSB dropped.
  function automatic logic [15:0] f_to_rgb565(input logic [c_nb_buf-1:0] i_w);
    logic [4:0] v_red5;
    logic [5:0] v_green6;
    logic [4:0] v_blue5;
    v_red5   = i_w[15:11];
    v_green6 = {i_w[10:6], i_w[10]};
    v_blue5  = i_w[5:1];
    if (c_swap_r_b) begin
      return {v_blue5, v_green6, v_red5};
    end else begin
      return {v_red5, v_green6, v_blue5};
    end
  endfunction

  assign w_cnt_nxt = r_cnt + c_one_w;

  // Frame read-out sequencer with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cap_we_en  <= 1'b1;
      r_oled_rst   <= 1'b1;
      r_fb_addr    <= {c_nb_img_pxls{1'b0}};
      r_cnt        <= {c_nb_img_pxls{1'b0}};
      r_color      <= 16'h0000;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_overrun    <= 1'b0;
      r_pre        <= 1'b0;
      r_np_d1      <= 1'b0;
      r_np_d2      <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_np_d1      <= 1'b0;
      r_np_d2      <= r_np_d1;
      if (r_np_d2) begin
        r_color <= f_to_rgb565(bus.fb_pxl);
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_WAIT_FRAME;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_FRAME: begin
          if (bus.cap_frame_done) begin
            r_state     <= S_PREFETCH;
            r_cap_we_en <= 1'b0;
            r_fb_addr   <= {c_nb_img_pxls{1'b0}};
            r_cnt       <= {c_nb_img_pxls{1'b0}};
            r_pre       <= 1'b0;
          end
        end
        S_PREFETCH: begin
          // First cycle lets the RAM read address 0, second registers it.
          if (r_pre) begin
            r_color    <= f_to_rgb565(bus.fb_pxl);
            r_oled_rst <= 1'b0;
            r_state    <= S_STREAM;
          end else begin
            r_pre <= 1'b1;
          end
        end
        S_STREAM: begin
          if (bus.oled_next_pixel) begin
            if (r_np_d1 || r_np_d2) begin
              r_overrun <= 1'b1;
            end
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt < c_pxls_w) begin
              r_fb_addr <= r_fb_addr + c_one_w;
              r_np_d1   <= 1'b1;
            end else begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + 8'd1;
              r_cap_we_en  <= 1'b1;
              r_oled_rst   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (i_continuous) begin
            r_state <= S_WAIT_FRAME;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cap_we_en <= 1'b1;
          r_oled_rst  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cap_we_en  = r_cap_we_en;
  assign bus.fb_addr    = r_fb_addr;
  assign bus.oled_rst   = r_oled_rst;
  assign bus.oled_color = r_color;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_oled_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_oled_frame_reader
// Directed sequence over a randomly filled frame buffer. The expected colour
// after the k-th consumed pixel is the RGB565 form of buffer word k (clamped
// to the last pixel), computed from the buffer contents held here.
// ---------------------------------------------------------------------------
module tb_oled_frame_reader;
  localparam int NPX = 4800;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       continuous;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       overrun;

  logic [15:0] mem [0:8191];
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  oled_frame_reader_if bus ();

  oled_frame_reader dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_continuous (continuous),
    .bus          (bus),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_frame_cnt  (frame_cnt),
    .o_overrun    (overrun)
  );

  // Frame buffer model: synchronous read, one cycle of latency.
  always @(posedge clk) bus.fb_pxl <= mem[bus.fb_addr];

  function automatic logic [15:0] ref_color(input logic [15:0] w);
    return {w[15:11], w[10:6], w[10], w[5:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    bus.cap_frame_done = 1'b0;
    bus.oled_next_pixel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Optionally request, wait for capture, then check the prefetch of pixel 0.
  task automatic arm(input bit use_start);
    if (use_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("busy_armed", busy, 1);
    repeat (10) tick();
    chk("we_before_capture", bus.cap_we_en, 1);
    bus.cap_frame_done = 1'b1;
    tick();
    bus.cap_frame_done = 1'b0;
    chk("we_frozen", bus.cap_we_en, 0);
    chk("addr_zero", bus.fb_addr, 0);
    chk("oled_rst_prefetch", bus.oled_rst, 1);
    tick();
    tick();
    chk("prefetch_color", bus.oled_color, ref_color(mem[0]));
    chk("oled_rst_stream", bus.oled_rst, 0);
  endtask

  // Consume pixels k0..n with the given pulse spacing (>= 3).
  task automatic stream(input int k0, input int n, input int gap, input bit inject);
    for (int k = k0; k <= n; k++) begin
      int cur;
      cur = (k < NPX) ? k : NPX - 1;
      bus.oled_next_pixel = 1'b1;
      if (inject && k == 100) begin
        start = 1'b1;
        bus.cap_frame_done = 1'b1;
      end
      tick();
      bus.oled_next_pixel = 1'b0;
      start = 1'b0;
      bus.cap_frame_done = 1'b0;
      chk("fb_addr", bus.fb_addr, cur);
      if (k == NPX) begin
        exp_cnt = (exp_cnt + 1) % 256;
        chk("frame_done_pulse", frame_done, 1);
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("we_released", bus.cap_we_en, 1);
        chk("oled_rst_done", bus.oled_rst, 1);
      end
      tick();
      chk("color_hold", bus.oled_color, ref_color(mem[k-1]));
      if (k == NPX) begin
        chk("frame_done_end", frame_done, 0);
        chk("busy_after_done", busy, continuous);
      end
      tick();
      chk("color_update", bus.oled_color, ref_color(mem[cur]));
      repeat (gap - 3) tick();
    end
    chk("no_overrun", overrun, 0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hFFFF;
    mem[1] = 16'b10101_01010_110011;

    // Reset state (sampled while reset is still held).
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    bus.cap_frame_done = 1'b0;
    bus.oled_next_pixel = 1'b0;
    tick();
    tick();
    chk("rst_we", bus.cap_we_en, 1);
    chk("rst_oled_rst", bus.oled_rst, 1);
    chk("rst_addr", bus.fb_addr, 0);
    chk("rst_color", bus.oled_color, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;

    // Capture done and next_pixel in IDLE are ignored.
    bus.cap_frame_done = 1'b1;
    tick();
    bus.cap_frame_done = 1'b0;
    chk("idle_cfd_busy", busy, 0);
    chk("idle_cfd_we", bus.cap_we_en, 1);
    bus.oled_next_pixel = 1'b1;
    tick();
    bus.oled_next_pixel = 1'b0;
    chk("idle_np_addr", bus.fb_addr, 0);
    chk("idle_np_overrun", overrun, 0);

    // start together with cap_frame_done: only start acts.
    start = 1'b1;
    bus.cap_frame_done = 1'b1;
    tick();
    start = 1'b0;
    bus.cap_frame_done = 1'b0;
    repeat (3) tick();
    chk("start_cfd_busy", busy, 1);
    chk("start_cfd_we", bus.cap_we_en, 1);

    // Single frame, 4-cycle spacing, known first two words.
    arm(1'b0);
    chk("color_ffff", bus.oled_color, 16'hFFFF);
    bus.oled_next_pixel = 1'b1;
    tick();
    bus.oled_next_pixel = 1'b0;
    tick();
    tick();
    chk("color_px1", bus.oled_color, 16'b10101_010100_11001);
    tick();
    stream(2, NPX, 4, 1'b0);
    chk("single_busy", busy, 0);
    chk("single_we", bus.cap_we_en, 1);
    chk("single_addr", bus.fb_addr, NPX - 1);
    chk("single_cnt", frame_cnt, 1);

    // Continuous over three frames, with stray start/cfd in STREAM.
    do_reset();
    continuous = 1'b1;
    arm(1'b1);
    stream(1, NPX, 3, 1'b1);
    tick();
    bus.oled_next_pixel = 1'b1;
    tick();
    bus.oled_next_pixel = 1'b0;
    chk("wait_np_addr", bus.fb_addr, NPX - 1);
    chk("wait_np_overrun", overrun, 0);
    chk("wait_busy", busy, 1);
    chk("wait_we", bus.cap_we_en, 1);
    arm(1'b0);
    stream(1, NPX, 3, 1'b0);
    arm(1'b0);
    continuous = 1'b0;
    stream(1, NPX, 3, 1'b0);
    chk("cont_cnt", frame_cnt, 3);
    chk("cont_idle", busy, 0);

    // Reset in the middle of STREAM.
    arm(1'b1);
    stream(1, 2000, 3, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_we", bus.cap_we_en, 1);
    chk("mid_rst_oled_rst", bus.oled_rst, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", bus.fb_addr, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_color", bus.oled_color, 0);
    rst = 1'b0;
    exp_cnt = 0;

    // Back-to-back next_pixel: overrun is sticky until reset.
    arm(1'b1);
    bus.oled_next_pixel = 1'b1;
    tick();
    tick();
    bus.oled_next_pixel = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_addr", bus.fb_addr, 2);
    repeat (20) tick();
    chk("ovr_sticky", overrun, 1);
    rst = 1'b1;
    tick();
    chk("ovr_rst", overrun, 0);
    rst = 1'b0;

    // Two cycles apart also overruns.
    arm(1'b1);
    bus.oled_next_pixel = 1'b1;
    tick();
    bus.oled_next_pixel = 1'b0;
    tick();
    chk("ovr2_clear", overrun, 0);
    bus.oled_next_pixel = 1'b1;
    tick();
    bus.oled_next_pixel = 1'b0;
    chk("ovr2_set", overrun, 1);
    chk("ovr2_addr", bus.fb_addr, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
